// File: rtl/dsp_dual_mult_acc_if.sv
// ---------------------------------------------------------------------------
// dsp_dual_mult_acc_if
// Handshake/data bundle for the packed dual multiplier-accumulator.
//   in_valid/in_ready/in_last : input beat handshake and group delimiter
//   a, b, c                   : operands (a, b signed; c per C_SIGNED)
//   ac, bc                    : accumulated products a*c and b*c
//   out_valid/out_ready       : result handshake
//   acc_ovf                   : result group exceeded ACC_LEN beats
// master = producer/consumer side, slave = the arithmetic block.
// ---------------------------------------------------------------------------
interface dsp_dual_mult_acc_if #(
  parameter int A_W     = 8,
  parameter int B_W     = 8,
  parameter int C_W     = 8,
  parameter int ACC_LEN = 1
);
  localparam int G = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 0;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [A_W-1:0]       a;
  logic [B_W-1:0]       b;
  logic [C_W-1:0]       c;
  logic [A_W+C_W+G-1:0] ac;
  logic [B_W+C_W+G-1:0] bc;
  logic                 out_valid;
  logic                 out_ready;
  logic                 acc_ovf;

  modport master (
    output in_valid, in_last, a, b, c, out_ready,
    input  in_ready, ac, bc, out_valid, acc_ovf
  );

  modport slave (
    input  in_valid, in_last, a, b, c, out_ready,
    output in_ready, ac, bc, out_valid, acc_ovf
  );
endinterface

// File: rtl/dsp_dual_mult_acc.sv
// ---------------------------------------------------------------------------
// dsp_dual_mult_acc
// Computes a*c and b*c with a single multiplier by packing a and b into one
// word (a shifted above a guard field holding b), then optionally accumulates
// both products over a group of up to ACC_LEN beats.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : dsp_dual_mult_acc_if.slave (input beats, results, handshakes)
// Pipeline: S0 input reg, S1 pre-add, S2 multiply, S3 accumulate,
//           S4 unpack/output. All stages freeze while the output is stalled.
// ---------------------------------------------------------------------------
module dsp_dual_mult_acc #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int C_W      = 8,
  parameter int C_SIGNED = 0,
  parameter int ACC_LEN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_dual_mult_acc_if.slave   bus
);
  localparam int G   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 0;
  localparam int SH  = B_W + C_W + G;       // lower (bc) field width
  localparam int ACW = A_W + C_W + G;       // upper (ac) field width
  localparam int PW  = A_W + SH + 1;        // packed word, one spare bit so a<<SH + b never wraps
  localparam int AW  = ACW + SH;            // accumulator width
  localparam int CW  = $clog2(ACC_LEN + 2); // beat counter width
  localparam logic [CW-1:0] CNT_MAX = CW'(ACC_LEN + 1);

  logic adv;

  // S0
  logic           s0_valid_reg, s0_last_reg;
  logic [A_W-1:0] s0_a_reg;
  logic [B_W-1:0] s0_b_reg;
  logic [C_W-1:0] s0_c_reg;
  // S1
  logic           s1_valid_reg, s1_last_reg;
  logic [PW-1:0]  s1_p_reg;
  logic [AW-1:0]  s1_c_reg;
  // S2
  logic           s2_valid_reg, s2_last_reg;
  logic [AW-1:0]  s2_prod_reg;
  // S3
  logic [AW-1:0]  acc_reg;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           first_reg, s3_done_reg, s3_ovf_reg;
  // S4
  logic           out_valid_reg, ovf_reg;
  logic [ACW-1:0] ac_reg;
  logic [SH-1:0]  bc_reg;

  logic [PW-1:0]  a_pre, b_pre;
  logic [AW-1:0]  c_ext, p_ext;

  assign adv          = !(out_valid_reg && !bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.ac       = ac_reg;
  assign bus.bc       = bc_reg;
  assign bus.acc_ovf  = ovf_reg;

  // a placed above the bc field; b sign-extended into the full packed word.
  assign a_pre = {s0_a_reg[A_W-1], s0_a_reg, {SH{1'b0}}};
  assign b_pre = {{(PW-B_W){s0_b_reg[B_W-1]}}, s0_b_reg};

  generate
    if (C_SIGNED != 0) begin : g_c_signed
      assign c_ext = {{(AW-C_W){s0_c_reg[C_W-1]}}, s0_c_reg};
    end else begin : g_c_unsigned
      assign c_ext = {{(AW-C_W){1'b0}}, s0_c_reg};
    end
  endgenerate

  // Only the low AW bits of the product are ever needed, so a modular
  // AW x AW multiply of sign-extended operands is exact.
  assign p_ext = {{(AW-PW){s1_p_reg[PW-1]}}, s1_p_reg};

  always_comb begin
    cnt_next = cnt_reg;
    if (first_reg)
      cnt_next = CW'(1);
    else if (cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid_reg  <= 1'b0;
      s0_last_reg   <= 1'b0;
      s0_a_reg      <= '0;
      s0_b_reg      <= '0;
      s0_c_reg      <= '0;
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_p_reg      <= '0;
      s1_c_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_prod_reg   <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      first_reg     <= 1'b1;
      s3_done_reg   <= 1'b0;
      s3_ovf_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      ac_reg        <= '0;
      bc_reg        <= '0;
    end else if (adv) begin
      // S0
      s0_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s0_a_reg    <= bus.a;
        s0_b_reg    <= bus.b;
        s0_c_reg    <= bus.c;
        s0_last_reg <= (ACC_LEN == 1) ? 1'b1 : bus.in_last;
      end
      // S1
      s1_valid_reg <= s0_valid_reg;
      s1_last_reg  <= s0_last_reg;
      s1_p_reg     <= a_pre + b_pre;
      s1_c_reg     <= c_ext;
      // S2
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      s2_prod_reg  <= p_ext * s1_c_reg;
      // S3: bubbles leave the accumulator and counter untouched
      s3_done_reg <= 1'b0;
      if (s2_valid_reg) begin
        acc_reg     <= first_reg ? s2_prod_reg : acc_reg + s2_prod_reg;
        cnt_reg     <= cnt_next;
        first_reg   <= s2_last_reg;
        s3_done_reg <= s2_last_reg;
        s3_ovf_reg  <= (ACC_LEN > 1) && s2_last_reg && (cnt_next == CNT_MAX);
      end
      // S4: upper field gets +1 when the lower field is negative (borrow)
      out_valid_reg <= s3_done_reg;
      if (s3_done_reg) begin
        bc_reg  <= acc_reg[SH-1:0];
        ac_reg  <= acc_reg[AW-1:SH] + ACW'(acc_reg[SH-1]);
        ovf_reg <= s3_ovf_reg;
      end
    end
  end
endmodule

// File: tb/tb_dsp_dual_mult_acc.sv
// ---------------------------------------------------------------------------
// tb_dsp_dual_mult_acc
// Three instances: defaults (u0), ACC_LEN = 9 (u9), C_SIGNED = 1 (us).
// Directed table for u0, hand-written group sequences for u9, random
// backpressure stream on u0.
// ---------------------------------------------------------------------------
module tb_dsp_dual_mult_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst9, rsts;

  dsp_dual_mult_acc_if #(.ACC_LEN(1)) bus0 ();
  dsp_dual_mult_acc_if #(.ACC_LEN(9)) bus9 ();
  dsp_dual_mult_acc_if #(.ACC_LEN(1)) buss ();

  dsp_dual_mult_acc #(.ACC_LEN(1)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
  dsp_dual_mult_acc #(.ACC_LEN(9)) u9 (.clk(clk), .rst(rst9), .bus(bus9));
  dsp_dual_mult_acc #(.C_SIGNED(1), .ACC_LEN(1)) us (.clk(clk), .rst(rsts), .bus(buss));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int c;
    int ac;
    int bc;
  } vec_t;

  vec_t vtab[7];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Wait (bounded) for out_valid on bus0; lat counts from the acceptance edge.
  task automatic wait0(output int lat);
    lat = 1;
    while (!bus0.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait9(output int lat);
    lat = 1;
    while (!bus9.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic waits(output int lat);
    lat = 1;
    while (!buss.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One beat on bus9; out_ready is held high so it is always accepted.
  task automatic beat9(input int a, input int b, input int c, input logic last);
    bus9.in_valid = 1'b1;
    bus9.a        = 8'(a);
    bus9.b        = 8'(b);
    bus9.c        = 8'(c);
    bus9.in_last  = last;
    @(negedge clk);
  endtask

  task automatic check9(input string nm, input int lat, input longint eac,
                        input longint ebc, input longint eovf);
    check({nm, " valid"}, bus9.out_valid, 1);
    check({nm, " lat"}, lat, 5);
    check({nm, " ac"}, longint'($signed(bus9.ac)), eac);
    check({nm, " bc"}, longint'($signed(bus9.bc)), ebc);
    check({nm, " ovf"}, bus9.acc_ovf, eovf);
    $display("%s: ac=%0d bc=%0d ovf=%0b lat=%0d", nm, $signed(bus9.ac),
             $signed(bus9.bc), bus9.acc_ovf, lat);
  endtask

  initial begin
    int lat;

    vtab[0] = '{a: -128, b: -128, c: 255, ac: -32640, bc: -32640};
    vtab[1] = '{a: 5,    b: -1,   c: 1,   ac: 5,      bc: -1};
    vtab[2] = '{a: 0,    b: 0,    c: 0,   ac: 0,      bc: 0};
    vtab[3] = '{a: 127,  b: 127,  c: 255, ac: 32385,  bc: 32385};
    vtab[4] = '{a: -1,   b: 127,  c: 255, ac: -255,   bc: 32385};
    vtab[5] = '{a: 3,    b: -7,   c: 100, ac: 300,    bc: -700};
    vtab[6] = '{a: 127,  b: -128, c: 0,   ac: 0,      bc: 0};

    {bus0.in_valid, bus0.in_last, bus0.a, bus0.b, bus0.c} = '0;
    {bus9.in_valid, bus9.in_last, bus9.a, bus9.b, bus9.c} = '0;
    {buss.in_valid, buss.in_last, buss.a, buss.b, buss.c} = '0;
    bus0.out_ready = 1'b1;
    bus9.out_ready = 1'b1;
    buss.out_ready = 1'b1;
    rst0 = 1'b0;
    rst9 = 1'b0;
    rsts = 1'b0;

    // ---- reset state ----
    #1;
    check("rst ac", bus0.ac, 0);
    check("rst bc", bus0.bc, 0);
    check("rst out_valid", bus0.out_valid, 0);
    check("rst acc_ovf", bus0.acc_ovf, 0);
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    rst9 = 1'b1;
    rsts = 1'b1;
    #1;
    check("rst in_ready", bus0.in_ready, 1);
    check("rst9 in_ready", bus9.in_ready, 1);

    // ---- directed table on defaults ----
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus0.in_valid = 1'b1;
      bus0.a = 8'(vtab[i].a);
      bus0.b = 8'(vtab[i].b);
      bus0.c = 8'(vtab[i].c);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      wait0(lat);
      check($sformatf("vec%0d valid", i), bus0.out_valid, 1);
      check($sformatf("vec%0d lat", i), lat, 5);
      check($sformatf("vec%0d ac", i), longint'($signed(bus0.ac)), vtab[i].ac);
      check($sformatf("vec%0d bc", i), longint'($signed(bus0.bc)), vtab[i].bc);
      check($sformatf("vec%0d ovf", i), bus0.acc_ovf, 0);
      $display("vec%0d: a=%0d b=%0d c=%0d -> ac=%0d bc=%0d lat=%0d", i, vtab[i].a,
               vtab[i].b, vtab[i].c, $signed(bus0.ac), $signed(bus0.bc), lat);
      if (i == 0) begin
        @(negedge clk);
        check("vec0 single-cycle valid", bus0.out_valid, 0);
      end
    end

    // ---- signed c ----
    @(negedge clk);
    buss.in_valid = 1'b1;
    buss.a = 8'(-128);
    buss.b = 8'(127);
    buss.c = 8'(-128);
    @(negedge clk);
    buss.in_valid = 1'b0;
    waits(lat);
    check("csigned valid", buss.out_valid, 1);
    check("csigned ac", longint'($signed(buss.ac)), 16384);
    check("csigned bc", longint'($signed(buss.bc)), -16256);
    $display("csigned: ac=%0d bc=%0d lat=%0d", $signed(buss.ac), $signed(buss.bc), lat);
    @(negedge clk);
    buss.in_valid = 1'b1;
    buss.a = 8'(-1);
    buss.b = 8'(1);
    buss.c = 8'(-1);
    @(negedge clk);
    buss.in_valid = 1'b0;
    waits(lat);
    check("csigned2 ac", longint'($signed(buss.ac)), 1);
    check("csigned2 bc", longint'($signed(buss.bc)), -1);
    $display("csigned2: ac=%0d bc=%0d lat=%0d", $signed(buss.ac), $signed(buss.bc), lat);

    // ---- ACC_LEN = 9: full 9-beat group ----
    @(negedge clk);
    for (int i = 0; i < 9; i++) beat9(127, -128, 255, i == 8);
    bus9.in_valid = 1'b0;
    wait9(lat);
    check9("acc9", lat, 291465, -293760, 0);

    // ---- overflow: 10 beats without last, last on 11 ----
    @(negedge clk);
    for (int i = 0; i < 11; i++) beat9(1, 1, 1, i == 10);
    bus9.in_valid = 1'b0;
    wait9(lat);
    check("ovf valid", bus9.out_valid, 1);
    check("ovf flag", bus9.acc_ovf, 1);
    $display("ovf group: ovf=%0b lat=%0d", bus9.acc_ovf, lat);
    @(negedge clk);
    for (int i = 0; i < 3; i++) beat9(2, -3, 10, i == 2);
    bus9.in_valid = 1'b0;
    wait9(lat);
    check9("post-ovf", lat, 60, -90, 0);

    // ---- reset mid-group ----
    @(negedge clk);
    for (int i = 0; i < 4; i++) beat9(5, 5, 5, 1'b0);
    bus9.in_valid = 1'b0;
    rst9 = 1'b0;
    #1;
    check("midrst ac", bus9.ac, 0);
    check("midrst bc", bus9.bc, 0);
    check("midrst out_valid", bus9.out_valid, 0);
    check("midrst ovf", bus9.acc_ovf, 0);
    $display("midrst: ac=%0d bc=%0d valid=%0b", $signed(bus9.ac), $signed(bus9.bc), bus9.out_valid);
    @(negedge clk);
    rst9 = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus9.out_valid) seen = 1'b1;
      end
      check("midrst no stale result", seen, 0);
    end
    for (int i = 0; i < 9; i++) beat9(-128, 127, 255, i == 8);
    bus9.in_valid = 1'b0;
    wait9(lat);
    check9("after-rst", lat, -293760, 291465, 0);

    // ---- backpressure stream on defaults ----
    begin
      int sent, got, cyc;
      logic stalled, accepted;
      logic [15:0] h_ac, h_bc;
      int q_ac[$];
      int q_bc[$];
      logic signed [7:0] ra, rb;
      logic [7:0] rc;
      sent = 0; got = 0; cyc = 0;
      stalled = 1'b0; accepted = 1'b0;
      h_ac = '0; h_bc = '0;
      ra = '0; rb = '0; rc = '0;
      @(negedge clk);
      while (got < 20 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        if (accepted) begin
          bus0.in_valid = 1'b0;
          accepted = 1'b0;
        end
        bus0.out_ready = ($urandom_range(0, 2) != 0);
        if (!bus0.in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          rc = 8'($urandom);
          bus0.in_valid = 1'b1;
          bus0.a = ra;
          bus0.b = rb;
          bus0.c = rc;
        end
        #1;
        check("bp in_ready", bus0.in_ready, !(bus0.out_valid && !bus0.out_ready));
        if (stalled) begin
          check("bp hold valid", bus0.out_valid, 1);
          check("bp hold ac", bus0.ac, h_ac);
          check("bp hold bc", bus0.bc, h_bc);
        end
        if (bus0.out_valid && bus0.out_ready) begin
          check("bp result expected", q_ac.size() > 0, 1);
          if (q_ac.size() > 0) begin
            int eac, ebc;
            eac = q_ac.pop_front();
            ebc = q_bc.pop_front();
            check($sformatf("bp%0d ac", got), longint'($signed(bus0.ac)), eac);
            check($sformatf("bp%0d bc", got), longint'($signed(bus0.bc)), ebc);
            $display("bp%0d: ac=%0d bc=%0d exp %0d %0d", got, $signed(bus0.ac),
                     $signed(bus0.bc), eac, ebc);
          end
          got++;
        end
        stalled = bus0.out_valid && !bus0.out_ready;
        h_ac = bus0.ac;
        h_bc = bus0.bc;
        if (bus0.in_valid && bus0.in_ready) begin
          q_ac.push_back(int'(ra) * int'(rc));
          q_bc.push_back(int'(rb) * int'(rc));
          sent++;
          accepted = 1'b1;
        end
      end
      check("bp completed in time", cyc < 1000, 1);
      check("bp result count", got, 20);
      check("bp sent count", sent, 20);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      repeat (8) @(negedge clk);
      check("bp no extra result", bus0.out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_dual_mult_acc.md
Name: dsp_dual_mult_acc

Overview:
Parametrised packed dual multiplier for conv layers. Computes a*c and b*c with one shared multiplier by packing a and b into a single pre-adder word. Optionally accumulates each product over a kernel window of up to ACC_LEN beats. Sits between the line-buffer/weight fetch and the requant stage, and adds valid/ready backpressure plus a signed/unsigned c mode.

Parameters:
A_W, 8, width of signed operand a
B_W, 8, width of signed operand b
C_W, 8, width of operand c
C_SIGNED, 0, 0 = c unsigned, 1 = c two's-complement
ACC_LEN, 1, maximum beats per accumulation group (1 = plain multiply); G = $clog2(ACC_LEN), so G = 0 when ACC_LEN = 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat when in_valid && in_ready
in_last  in  1  final beat of the accumulation group; ignored (treated as 1) when ACC_LEN = 1
a  in  A_W  signed operand
b  in  B_W  signed operand
c  in  C_W  shared operand, signedness per C_SIGNED
ac  out  A_W+C_W+G  signed sum of a*c over the group
bc  out  B_W+C_W+G  signed sum of b*c over the group
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
acc_ovf  out  1  group exceeded ACC_LEN beats; qualifies the current result

Behaviour:
- Reset (rst = 0, async): all pipeline, valid, accumulator and beat-count registers clear. Outputs: ac = 0, bc = 0, out_valid = 0, acc_ovf = 0. in_ready = 1 after release.
- Reset mid-operation aborts any partial group; no stale result is emitted after release.
- Packing: SH = B_W+C_W+G. Packed word P_in = (sext(a) << SH) + sext(b). c is zero-extended (C_SIGNED = 0) or sign-extended (C_SIGNED = 1) by 1 bit. Product P = P_in * c_ext, full precision, signed.
- Pipeline, each stage advancing only on adv = !(out_valid && !out_ready):
  - S0: register a, b, c, last, valid.
  - S1: pre-add.
  - S2: multiply.
  - S3: accumulate.
  - S4: unpack and output register.
- Bubbles carry valid = 0 and never modify the accumulator.
- in_ready = adv, combinational from out_valid and out_ready.
- Accumulator (S3), per valid beat: acc <= (first beat of group ? P : acc + P).
  - A beat is the first of its group if it follows reset or a beat with last = 1.
  - On a last beat, the group is handed to S4 and the next beat starts a new group.
- Unpack (S4): bc = acc[SH-1:0]; ac = acc[top:SH] + acc[SH-1]. The added bit is the borrow correction from the negative lower field.
- Latency: 5 adv-cycles from acceptance of the last beat to out_valid.
- Throughput: one beat per cycle with no stall.
- One result per group. out_valid holds, and ac/bc/acc_ovf stay stable, until out_ready is sampled high.
- Stall: while out_valid && !out_ready, every stage freezes and in_ready = 0. Simultaneous out_ready = 1 and a new beat arriving: both transfer in the same cycle.
- Beat counter: counts beats in the current group and saturates at ACC_LEN+1.
  - If a group reaches ACC_LEN+1 beats before last, acc_ovf = 1 is emitted with that group's result.
  - In that case ac/bc are wrapped modulo their field widths and are not guaranteed.
  - The counter clears on the first beat of the next group.
- ACC_LEN = 1: every beat produces a result and acc_ovf is always 0.
- Arithmetic is exact for all operand values within ACC_LEN beats, including the most-negative values of a, b and c.

Test Plan:
- Defaults: a = -128, b = -128, c = 255 -> after 5 cycles ac = -32640, bc = -32640, out_valid for 1 cycle.
- Defaults: a = 5, b = -1, c = 1 -> ac = 5, bc = -1. Checks borrow correction at the lower-field boundary.
- ACC_LEN = 9: 9 beats of a = 127, b = -128, c = 255, in_last on beat 9 -> ac = 291465, bc = -293760, acc_ovf = 0, out_valid 5 cycles after beat 9.
- C_SIGNED = 1: a = -128, b = 127, c = -128 -> ac = 16384, bc = -16256.
- Backpressure: stream 20 random beats, out_ready toggling pseudo-randomly -> results in order, none lost or duplicated, all match the reference model, outputs stable while stalled, in_ready = 0 exactly when out_valid && !out_ready.
- ACC_LEN = 9, 10 beats without last, then last on beat 11 -> acc_ovf = 1 on that result. Next group of 3 beats produces a correct sum with acc_ovf = 0.
- Reset asserted mid-group (after beat 4 of 9) -> outputs 0 immediately. A fresh 9-beat group after release yields the correct sum.
